sobel_grad: RTL and testbench

Streaming 3x3 Sobel gradient generator: accepts a raster-order pixel stream over valid/ready and emits signed horizontal/vertical gradient pairs (gx, gy) over valid/ready. It is the producer side of the gradient interface consumed by the magnitude stage, and sits between pixel capture and magnitude/threshold in the vision pipeline. Two line buffers plus a 3x3 window register form the full neighbourhood with no frame store.

---
 rtl/sobel_grad_pkg.sv | 34 +++
 rtl/sobel_grad_if.sv | 25 ++
 rtl/sobel_grad_line_buffer.sv | 24 ++
 rtl/sobel_grad.sv | 130 +++++++++++++
 tb/tb_sobel_grad.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/sobel_grad_pkg.sv
// rtl/sobel_grad_pkg.sv - shared pixel/gradient types, Sobel kernel weights and gradient function
package sobel_pkg;

    localparam int PIX_W  = 8;
    localparam int GRAD_W = PIX_W + 3;

    typedef logic [PIX_W-1:0]         pixel_t;
    typedef logic signed [GRAD_W-1:0] grad_t;
    typedef pixel_t                   window_t [3][3];

    typedef struct packed {
        grad_t gx;
        grad_t gy;
    } grad_pair_t;

    // Separable smoothing weights (1, 2, 1) across the derivative direction
    localparam grad_t K_EDGE   = grad_t'(1);
    localparam grad_t K_CENTRE = grad_t'(2);

    function automatic grad_t ext(input pixel_t p);
        return grad_t'(p);
    endfunction

    // p[row][col]: row 0 is the top (oldest) line, col 0 the leftmost (oldest) column
    function automatic grad_pair_t sobel_compute(input window_t p);
        grad_pair_t res;
        res.gx = (K_EDGE * ext(p[0][2]) + K_CENTRE * ext(p[1][2]) + K_EDGE * ext(p[2][2]))
               - (K_EDGE * ext(p[0][0]) + K_CENTRE * ext(p[1][0]) + K_EDGE * ext(p[2][0]));
        res.gy = (K_EDGE * ext(p[2][0]) + K_CENTRE * ext(p[2][1]) + K_EDGE * ext(p[2][2]))
               - (K_EDGE * ext(p[0][0]) + K_CENTRE * ext(p[0][1]) + K_EDGE * ext(p[0][2]));
        return res;
    endfunction

endpackage

// File: rtl/sobel_grad_if.sv
// rtl/sobel_grad_if.sv - pixel-in / gradient-out handshake bundle for sobel_grad
interface sobel_grad_if #(
    parameter int PixelWidth = 8,
    parameter int GradWidth  = PixelWidth + 3
);

    logic                        valid_i;
    logic [PixelWidth-1:0]       pixel_i;
    logic                        ready_o;
    logic                        valid_o;
    logic signed [GradWidth-1:0] gx_o;
    logic signed [GradWidth-1:0] gy_o;
    logic                        ready_i;

    modport master (
        output valid_i, pixel_i, ready_i,
        input  ready_o, valid_o, gx_o, gy_o
    );

    modport slave (
        input  valid_i, pixel_i, ready_i,
        output ready_o, valid_o, gx_o, gy_o
    );

endinterface

// File: rtl/sobel_grad_line_buffer.sv
// rtl/sobel_grad_line_buffer.sv - one-line pixel store, synchronous write and combinational read
module line_buffer #(
    parameter int Width = 8,
    parameter int Depth = 320
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(Depth)-1:0] addr,
    input  logic [Width-1:0]         wr_data,
    output logic [Width-1:0]         rd_data
);

    // Contents are deliberately unreset; every entry is rewritten before it can reach an output
    logic [Width-1:0] mem [Depth];

    assign rd_data = mem[addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/sobel_grad.sv
// rtl/sobel_grad.sv - streaming 3x3 Sobel gx/gy generator; SOBEL_GRAD_BORDER_EN emits zeros at incomplete windows
module sobel_grad
    import sobel_pkg::*;
#(
    parameter int PixelWidth  = PIX_W,
    parameter int LineWidth   = 320,
    parameter int FrameHeight = 240,
    parameter int GradWidth   = PixelWidth + 3
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    sobel_grad_if.slave bus
);

    localparam int ColW = $clog2(LineWidth);
    localparam int RowW = $clog2(FrameHeight);

    logic [ColW-1:0] col;
    logic [RowW-1:0] row;
    logic            accept;
    logic            complete;
    logic            produce;
    logic            col_last;
    logic            row_last;

    pixel_t     pix_in;
    pixel_t     lb0_rd;
    pixel_t     lb1_rd;
    window_t    win;
    window_t    win_next;
    grad_pair_t grad;

    logic                        out_valid;
    logic signed [GradWidth-1:0] out_gx;
    logic signed [GradWidth-1:0] out_gy;

    assign pix_in     = bus.pixel_i;
    assign bus.ready_o = !out_valid | bus.ready_i;
    assign bus.valid_o = out_valid;
    assign bus.gx_o    = out_gx;
    assign bus.gy_o    = out_gy;

    assign accept   = bus.valid_i & bus.ready_o;
    assign col_last = (col == ColW'(LineWidth - 1));
    assign row_last = (row == RowW'(FrameHeight - 1));
    assign complete = (row >= RowW'(2)) && (col >= ColW'(2));

`ifdef SOBEL_GRAD_BORDER_EN
    assign produce = accept;
`else
    assign produce = accept & complete;
`endif

    // lb0 holds the previous line; lb1 takes lb0's old entry, so it trails by one more line
    line_buffer #(
        .Width (PixelWidth),
        .Depth (LineWidth)
    ) u_lb0 (
        .clk     (clk_i),
        .wr_en   (accept),
        .addr    (col),
        .wr_data (pix_in),
        .rd_data (lb0_rd)
    );

    line_buffer #(
        .Width (PixelWidth),
        .Depth (LineWidth)
    ) u_lb1 (
        .clk     (clk_i),
        .wr_en   (accept),
        .addr    (col),
        .wr_data (lb0_rd),
        .rd_data (lb1_rd)
    );

    always_comb begin
        win_next = win;
        for (int r = 0; r < 3; r++) begin
            win_next[r][0] = win[r][1];
            win_next[r][1] = win[r][2];
        end
        win_next[0][2] = lb1_rd;
        win_next[1][2] = lb0_rd;
        win_next[2][2] = pix_in;
    end

    assign grad = sobel_compute(win_next);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col <= '0;
            row <= '0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (accept) begin
            win <= win_next;
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + RowW'(1);
            end else begin
                col <= col + ColW'(1);
            end
        end
    end

    // A load takes priority over a drain so back-to-back results flow without a bubble
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid <= 1'b0;
            out_gx    <= '0;
            out_gy    <= '0;
        end else if (produce) begin
            out_valid <= 1'b1;
`ifdef SOBEL_GRAD_BORDER_EN
            out_gx    <= complete ? GradWidth'(grad.gx) : '0;
            out_gy    <= complete ? GradWidth'(grad.gy) : '0;
`else
            out_gx    <= GradWidth'(grad.gx);
            out_gy    <= GradWidth'(grad.gy);
`endif
        end else if (bus.ready_i) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sobel_grad.sv
// tb/tb_sobel_grad.sv - directed self-checking bench for sobel_grad on a 4x4 frame
module tb_sobel_grad;

`ifdef SOBEL_GRAD_BORDER_EN
    localparam bit BORDER = 1'b1;
`else
    localparam bit BORDER = 1'b0;
`endif
    localparam int EXP_N = BORDER ? 16 : 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    logic signed [10:0] got_gx [$];
    logic signed [10:0] got_gy [$];

    sobel_grad_if #(.PixelWidth(8), .GradWidth(11)) bus ();

    sobel_grad #(
        .PixelWidth  (8),
        .LineWidth   (4),
        .FrameHeight (4),
        .GradWidth   (11)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && bus.valid_o && bus.ready_i) begin
            got_gx.push_back(bus.gx_o);
            got_gy.push_back(bus.gy_o);
        end
    end

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // 0: constant 77, 1: vertical edge, 2: mirrored vertical edge, 3: horizontal edge
    function automatic logic [7:0] pix(input int kind, input int r, input int c);
        case (kind)
            0:       return 8'd77;
            1:       return (c >= 2) ? 8'd255 : 8'd0;
            2:       return (c < 2) ? 8'd255 : 8'd0;
            default: return (r >= 2) ? 8'd100 : 8'd0;
        endcase
    endfunction

    task automatic send_pixel(input logic [7:0] p);
        int n;
        n = 0;
        bus.valid_i = 1'b1;
        bus.pixel_i = p;
        @(negedge clk);
        while (!bus.ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", bus.ready_o, 1);
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
    endtask

    task automatic drain();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int kind);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                send_pixel(pix(kind, r, c));
            end
        end
        drain();
    endtask

    task automatic check_frame(input string tag, input int exp_gx, input int exp_gy);
        int r;
        int c;
        bit full;
        check($sformatf("%s_count", tag), got_gx.size(), EXP_N);
        for (int i = 0; i < got_gx.size() && i < EXP_N; i++) begin
            r    = BORDER ? i / 4 : 2 + i / 2;
            c    = BORDER ? i % 4 : 2 + i % 2;
            full = (r >= 2) && (c >= 2);
            check($sformatf("%s_gx[%0d]", tag, i), got_gx[i], full ? exp_gx : 0);
            check($sformatf("%s_gy[%0d]", tag, i), got_gy[i], full ? exp_gy : 0);
        end
        got_gx.delete();
        got_gy.delete();
    endtask

    initial begin
        bus.valid_i = 1'b0;
        bus.pixel_i = '0;
        bus.ready_i = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_valid", bus.valid_o, 0);
        check("reset_gx", bus.gx_o, 0);
        check("reset_gy", bus.gy_o, 0);
        check("reset_ready", bus.ready_o, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_release_ready", bus.ready_o, 1);
        @(posedge clk);
        #1;

        send_frame(0);
        check_frame("const77", 0, 0);
        send_frame(1);
        check_frame("vedge", 1020, 0);
        send_frame(2);
        check_frame("mirror", -1020, 0);
        send_frame(3);
        check_frame("hedge", 0, 400);

        // Stall the output right after the first complete window (2,2)
        for (int k = 0; k < 11; k++) begin
            send_pixel(pix(1, k / 4, k % 4));
        end
        bus.ready_i = 1'b0;
        bus.valid_i = 1'b1;
        bus.pixel_i = pix(1, 2, 3);
        repeat (5) begin
            @(negedge clk);
            check("stall_ready", bus.ready_o, 0);
            check("stall_valid", bus.valid_o, 1);
            check("stall_gx", bus.gx_o, 1020);
            check("stall_gy", bus.gy_o, 0);
        end
        @(posedge clk);
        #1;
        bus.ready_i = 1'b1;
        for (int k = 11; k < 16; k++) begin
            send_pixel(pix(1, k / 4, k % 4));
        end
        drain();
        check_frame("stall", 1020, 0);

        // Mid-frame reset after 7 pixels of a different value
        for (int k = 0; k < 7; k++) begin
            send_pixel(8'd200);
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset_valid", bus.valid_o, 0);
        check("midreset_ready", bus.ready_o, 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        got_gx.delete();
        got_gy.delete();
        send_frame(0);
        check_frame("post_reset", 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
